dpram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that acts as the initiator on the dual-port RAM's read and write ports.
- Generates write/read strobes and addresses, and forwards push data to the RAM.
- Captures RAM read data, which has 1-cycle latency.
- Presents a push/pop FIFO interface with status flags to the surrounding datapath.
- The dual-port RAM is instantiated alongside, at the same level; its ports connect 1:1 to this block's ram_* ports.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 37 +++
 rtl/dpram_fifo_ctrl.sv | 146 ++++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the dual-port RAM FIFO controller
//
// Purpose : default geometry of the FIFO and the wrap-bit pointer type.
// Ports   : none (package).
// Options : none here; see dpram_fifo_ctrl.sv for FIFO_ERR_FLAGS_EN.
package fifo_pkg;

  localparam int RAM_WIDTH_D = 8;
  localparam int ADD_SIZE_D  = 4;
  localparam int RAM_DEPTH_D = 16;

  // Pointer carries one extra MSB beyond the RAM address: the wrap bit.
  localparam int PTR_W_D = ADD_SIZE_D + 1;
  typedef logic [PTR_W_D-1:0] ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-bit pointer counter with increment enable
//
// Purpose : (add_size+1)-bit counter that wraps naturally at 2**(add_size+1).
//           The low add_size bits address the RAM, the MSB is the wrap bit.
// Ports   : i_clk      clock, rising edge
//           i_rst      asynchronous active-high reset (pointer -> 0)
//           i_inc      advance the pointer by one at the next edge
//           o_ptr      current registered pointer
//           o_ptr_next value the pointer takes at the next edge
// Options : none.
module fifo_ptr #(
  parameter int add_size = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  output logic [add_size:0] o_ptr,
  output logic [add_size:0] o_ptr_next
);

  logic [add_size:0] r_ptr;
  logic [add_size:0] w_ptr_next;

  assign w_ptr_next = r_ptr + {{add_size{1'b0}}, i_inc};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign o_ptr      = r_ptr;
  assign o_ptr_next = w_ptr_next;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - synchronous FIFO controller driving a dual-port RAM
//
// Purpose : initiator on both ports of an external dual-port RAM (registered
//           read, 1-cycle latency). Presents push/pop with full/empty/count.
// Ports   : clk, rst                 clock / async active-high reset
//           wr_en, wr_data, full     push side
//           rd_en, rd_data, rd_valid pop side (rd_valid one cycle after pop)
//           empty, count             status (registered)
//           ram_write, ram_write_add, ram_data_in   RAM write port
//           ram_read, ram_read_add, ram_data_out    RAM read port
//           overflow, underflow      sticky error flags (optional)
// Options : FIFO_ERR_FLAGS_EN adds the overflow/underflow outputs.
module dpram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ram_width = RAM_WIDTH_D,
  parameter int ram_depth = RAM_DEPTH_D,
  parameter int add_size  = ADD_SIZE_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ram_width-1:0] wr_data,
  output logic                 full,
  input  logic                 rd_en,
  output logic [ram_width-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic [add_size:0]    count,
  output logic                 ram_write,
  output logic [add_size-1:0]  ram_write_add,
  output logic [ram_width-1:0] ram_data_in,
  output logic                 ram_read,
  output logic [add_size-1:0]  ram_read_add,
  input  logic [ram_width-1:0] ram_data_out
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  generate
    if (ram_depth != (1 << add_size)) begin : g_bad_depth
      $error("dpram_fifo_ctrl: ram_depth must equal 2**add_size");
    end
  endgenerate

  logic [add_size:0]    w_wr_ptr;
  logic [add_size:0]    w_wr_next;
  logic [add_size:0]    w_rd_ptr;
  logic [add_size:0]    w_rd_next;
  logic [add_size:0]    w_count_next;
  logic                 w_push;
  logic                 w_pop;

  logic                 r_full;
  logic                 r_empty;
  logic [add_size:0]    r_count;
  logic                 r_rd_valid;
  logic [ram_width-1:0] r_rd_hold;

  // Acceptance uses the registered flags only, so a push into a full FIFO is
  // blocked even when a pop frees an entry in the same cycle.
  assign w_push = wr_en & ~r_full;
  assign w_pop  = rd_en & ~r_empty;

  fifo_ptr #(.add_size(add_size)) u_wr_ptr (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_inc      (w_push),
    .o_ptr      (w_wr_ptr),
    .o_ptr_next (w_wr_next)
  );

  fifo_ptr #(.add_size(add_size)) u_rd_ptr (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_inc      (w_pop),
    .o_ptr      (w_rd_ptr),
    .o_ptr_next (w_rd_next)
  );

  assign w_count_next = w_wr_next - w_rd_next;

  // Flags are registered from the next pointer values so they line up with
  // the pointers themselves at every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_count <= '0;
    end else begin
      r_empty <= (w_wr_next == w_rd_next);
      r_full  <= (w_wr_next[add_size-1:0] == w_rd_next[add_size-1:0]) &&
                 (w_wr_next[add_size] != w_rd_next[add_size]);
      r_count <= w_count_next;
    end
  end

  // The RAM's output register presents the word during the cycle after the
  // read strobe; it is passed straight through then and held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_hold  <= '0;
    end else begin
      r_rd_valid <= w_pop;
      if (r_rd_valid) begin
        r_rd_hold <= ram_data_out;
      end
    end
  end

  assign rd_data  = r_rd_valid ? ram_data_out : r_rd_hold;
  assign rd_valid = r_rd_valid;

  assign ram_write     = w_push;
  assign ram_write_add = w_wr_ptr[add_size-1:0];
  assign ram_data_in   = wr_data;
  assign ram_read      = w_pop;
  assign ram_read_add  = w_rd_ptr[add_size-1:0];

  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (wr_en & r_full);
      r_underflow <= r_underflow | (rd_en & r_empty);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - self-checking bench for dpram_fifo_ctrl with a RAM model
module tb_dpram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic [4:0] count;
  logic       ram_write;
  logic [3:0] ram_write_add;
  logic [7:0] ram_data_in;
  logic       ram_read;
  logic [3:0] ram_read_add;
  logic [7:0] ram_data_out;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  dpram_fifo_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .count         (count),
    .ram_write     (ram_write),
    .ram_write_add (ram_write_add),
    .ram_data_in   (ram_data_in),
    .ram_read      (ram_read),
    .ram_read_add  (ram_read_add),
    .ram_data_out  (ram_data_out)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow      (overflow),
    .underflow     (underflow)
`endif
  );

  // Dual-port RAM with registered read output.
  logic [7:0] mem [16];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_data_out <= 8'h00;
    end else begin
      if (ram_write) mem[ram_write_add] <= ram_data_in;
      if (ram_read)  ram_data_out <= mem[ram_read_add];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int passes = 0;

  // Reference model: occupancy as a queue, addresses as counts of accepted ops.
  logic [7:0] q[$];
  int         n_push = 0;
  int         n_pop  = 0;
  logic [7:0] last_rd = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ov = 1'b0;
  logic       exp_un = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    n_push = 0;
    n_pop = 0;
    last_rd = 8'h00;
    exp_valid = 1'b0;
    exp_ov = 1'b0;
    exp_un = 1'b0;
  endtask

  task automatic chk_status();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 16));
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    chk("rd_data", 32'(rd_data), 32'(last_rd));
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", 32'(overflow), 32'(exp_ov));
    chk("underflow", 32'(underflow), 32'(exp_un));
`endif
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    bit acc_w;
    bit acc_r;
    wr_en = w;
    rd_en = r;
    wr_data = d;
    #1;
    acc_w = w && (q.size() < 16);
    acc_r = r && (q.size() > 0);
    if (w && q.size() == 16) exp_ov = 1'b1;
    if (r && q.size() == 0)  exp_un = 1'b1;
    chk("ram_write", 32'(ram_write), 32'(acc_w));
    chk("ram_read", 32'(ram_read), 32'(acc_r));
    if (acc_w) begin
      chk("ram_write_add", 32'(ram_write_add), 32'(n_push % 16));
      chk("ram_data_in", 32'(ram_data_in), 32'(d));
    end
    if (acc_r) chk("ram_read_add", 32'(ram_read_add), 32'(n_pop % 16));
    @(posedge clk);
    #1;
    exp_valid = acc_r;
    if (acc_r) begin
      last_rd = q.pop_front();
      n_pop++;
    end
    if (acc_w) begin
      q.push_back(d);
      n_push++;
    end
    chk_status();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = 8'h00;
    #12;
    model_reset();
    chk_status();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three pushes then three back-to-back pops, then a hold cycle.
    cyc(1, 0, 8'h11);
    cyc(1, 0, 8'h22);
    cyc(1, 0, 8'h33);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);

    // Pop while empty is ignored.
    cyc(0, 1, 8'h00);

    // Fill to full, then one rejected push.
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i));
    cyc(1, 0, 8'hEE);

    // Push and pop together while full: only the pop is accepted.
    cyc(1, 1, 8'hDD);

    // Streaming push+pop at constant occupancy; addresses wrap past 15.
    for (int i = 0; i < 40; i++) cyc(1, 1, 8'($urandom_range(0, 255)));

    // Drain, then push+pop together while empty: push only.
    while (q.size() > 0) cyc(0, 1, 8'h00);
    cyc(1, 1, 8'h5A);
    cyc(0, 1, 8'h00);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    // Asynchronous reset between edges while a pop result is showing.
    cyc(1, 0, 8'h77);
    cyc(1, 0, 8'h78);
    cyc(0, 1, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_status();
    cyc(1, 0, 8'hA5);
    cyc(0, 1, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
